// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Observes a multiplexed, active-low seven-segment display bus and recovers
// the hex digits being shown. Both buses are synchronized, each digit must
// be stable for STABLE_CYCLES synchronized samples before it is captured,
// and a complete scan frame is published as one word with a valid strobe.
//
// Ports
//   clk        in   system clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   seg_in     in   [6:0] segment lines {g,f,e,d,c,b,a}, 0 = lit, async
//   an_in      in   [NUM_DIGITS-1:0] digit selects, active-low one-hot, async
//   hex_out    out  [4*NUM_DIGITS-1:0] decoded word, digit i at [4i+3:4i]
//   blank_out  out  [NUM_DIGITS-1:0] digit i was captured all-dark
//   err_out    out  [NUM_DIGITS-1:0] digit i held an unrecognized pattern
//   valid      out  one-cycle strobe marking a new published frame
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    output logic [4*NUM_DIGITS-1:0]   hex_out,
    output logic [NUM_DIGITS-1:0]     blank_out,
    output logic [NUM_DIGITS-1:0]     err_out,
    output logic                      valid
);

    // Counter value reached on the capturing edge, and the value just before.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_ARM  = 8'(STABLE_CYCLES - 2);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PUBLISH = 1'b1
    } state_t;

    // Returns {err, blank, nibble} for one segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'b1000000: res = {2'b00, 4'h0};
            7'b1111001: res = {2'b00, 4'h1};
            7'b0100100: res = {2'b00, 4'h2};
            7'b0110000: res = {2'b00, 4'h3};
            7'b0011001: res = {2'b00, 4'h4};
            7'b0010010: res = {2'b00, 4'h5};
            7'b0000010: res = {2'b00, 4'h6};
            7'b1111000: res = {2'b00, 4'h7};
            7'b0000000: res = {2'b00, 4'h8};
            7'b0010000: res = {2'b00, 4'h9};
            7'b0001000: res = {2'b00, 4'hA};
            7'b0000011: res = {2'b00, 4'hB};
            7'b1000110: res = {2'b00, 4'hC};
            7'b0100001: res = {2'b00, 4'hD};
            7'b0000110: res = {2'b00, 4'hE};
            7'b0001110: res = {2'b00, 4'hF};
            7'b1111111: res = {2'b01, 4'h0};
            default:    res = {2'b10, 4'h0};
        endcase
        return res;
    endfunction

    // True when exactly one select bit is active (low).
    function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
        logic [NUM_DIGITS-1:0] sel;
        sel = ~an;
        return (sel != {NUM_DIGITS{1'b0}}) &&
               ((sel & (sel - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == {NUM_DIGITS{1'b0}});
    endfunction

    logic [6:0]              seg_meta_q, seg_sync_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   an_meta_q,  an_sync_q,  an_prev_q;
    logic [7:0]              stab_cnt_q, stab_cnt_d;
    logic [4*NUM_DIGITS-1:0] stg_hex_q;
    logic [NUM_DIGITS-1:0]   stg_blank_q, stg_err_q;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] hex_q;
    logic [NUM_DIGITS-1:0]   blank_q, err_q;
    logic                    valid_q;

    logic                    an_legal_s;
    logic                    pair_same_s;
    logic                    capture_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic [NUM_DIGITS-1:0]   cap_mask_s;
    logic [5:0]              dec_s;
    logic                    publish_s;

    assign an_legal_s  = one_low(an_sync_q);
    assign pair_same_s = (seg_sync_q == seg_prev_q) && (an_sync_q == an_prev_q);
    assign sel_s       = ~an_sync_q;
    assign dec_s       = decode_seg(seg_sync_q);
    // Capture fires only on the edge the counter climbs to its last value,
    // so a digit that keeps dwelling is not captured a second time.
    assign capture_s   = an_legal_s && pair_same_s && (stab_cnt_q == CNT_ARM);
    assign cap_mask_s  = capture_s ? sel_s : {NUM_DIGITS{1'b0}};

    // Two-flop synchronizer plus previous-sample register; resets to dark/none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= 7'h7F;
            seg_sync_q <= 7'h7F;
            seg_prev_q <= 7'h7F;
            an_meta_q  <= {NUM_DIGITS{1'b1}};
            an_sync_q  <= {NUM_DIGITS{1'b1}};
            an_prev_q  <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_meta_q <= seg_in;
            seg_sync_q <= seg_meta_q;
            seg_prev_q <= seg_sync_q;
            an_meta_q  <= an_in;
            an_sync_q  <= an_meta_q;
            an_prev_q  <= an_sync_q;
        end
    end

    // Stability counter next state: reload on change or illegal select, saturate.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (!an_legal_s) begin
            stab_cnt_d = 8'd0;
        end else if (!pair_same_s) begin
            stab_cnt_d = 8'd0;
        end else if (stab_cnt_q != CNT_LAST) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
    end

    // Stability counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_q <= 8'd0;
        end else begin
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Staging entries; a later capture of the same digit overwrites the earlier one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_hex_q   <= {(4*NUM_DIGITS){1'b0}};
            stg_blank_q <= {NUM_DIGITS{1'b0}};
            stg_err_q   <= {NUM_DIGITS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask_s[i]) begin
                    stg_hex_q[4*i +: 4] <= dec_s[3:0];
                    stg_blank_q[i]      <= dec_s[4];
                    stg_err_q[i]        <= dec_s[5];
                end
            end
        end
    end

    // Frame FSM state and seen-mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            seen_q  <= {NUM_DIGITS{1'b0}};
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
        end
    end

    // Frame FSM next state; a capture during PUBLISH seeds the next frame.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        case (state_q)
            ST_COLLECT: begin
                seen_d = seen_q | cap_mask_s;
                if (&seen_d) begin
                    state_d = ST_PUBLISH;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_PUBLISH: begin
                seen_d  = cap_mask_s;
                state_d = ST_COLLECT;
            end
            default: begin
                seen_d  = {NUM_DIGITS{1'b0}};
                state_d = ST_COLLECT;
            end
        endcase
    end

    // Frame FSM output decode.
    always_comb begin
        publish_s = 1'b0;
        case (state_q)
            ST_COLLECT: publish_s = 1'b0;
            ST_PUBLISH: publish_s = 1'b1;
            default:    publish_s = 1'b0;
        endcase
    end

    // Published outputs; staging is sampled before any same-edge capture lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q   <= {(4*NUM_DIGITS){1'b0}};
            blank_q <= {NUM_DIGITS{1'b0}};
            err_q   <= {NUM_DIGITS{1'b0}};
            valid_q <= 1'b0;
        end else begin
            valid_q <= publish_s;
            if (publish_s) begin
                hex_q   <= stg_hex_q;
                blank_q <= stg_blank_q;
                err_q   <= stg_err_q;
            end
        end
    end

    assign hex_out   = hex_q;
    assign blank_out = blank_q;
    assign err_out   = err_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// Bench for seg7_scan_decoder (4 digits, 4 stable cycles). A reference model
// works from the raw input run length: a digit whose {seg, an} has been seen
// unchanged for exactly STABLE_CYCLES input samples is captured two edges
// later; a completed frame publishes on the following edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] an_in;
    logic [15:0]   hex_out;
    logic [ND-1:0] blank_out;
    logic [ND-1:0] err_out;
    logic          valid;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_in   (seg_in),
        .an_in    (an_in),
        .hex_out  (hex_out),
        .blank_out(blank_out),
        .err_out  (err_out),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] code_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_cmp = 0;
    int n_bad = 0;
    int vcount = 0;
    int edge_cnt = 0;

    // reference model state
    logic [6:0]  m_last_seg;
    logic [3:0]  m_last_an;
    int          m_run;
    logic        pipe_v   [2];
    logic [6:0]  pipe_seg [2];
    logic [3:0]  pipe_an  [2];
    logic [3:0]  m_nib    [4];
    logic [3:0]  m_blank, m_err, m_seen;
    logic        m_pub;
    logic [15:0] exp_hex;
    logic [3:0]  exp_blank, exp_err;
    logic        exp_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int count_low(input logic [3:0] an);
        int c = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_last_seg = 7'h7F;
        m_last_an  = 4'hF;
        m_run      = 1000;
        for (int i = 0; i < 2; i++) begin
            pipe_v[i] = 1'b0; pipe_seg[i] = 7'h7F; pipe_an[i] = 4'hF;
        end
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_blank = 4'h0; m_err = 4'h0; m_seen = 4'h0; m_pub = 1'b0;
        exp_hex = 16'h0; exp_blank = 4'h0; exp_err = 4'h0; exp_valid = 1'b0;
    endtask

    task automatic model_step();
        int d;
        int v;
        edge_cnt++;
        exp_valid = 1'b0;
        if (m_pub) begin
            exp_valid = 1'b1;
            exp_hex   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            exp_blank = m_blank;
            exp_err   = m_err;
            m_pub     = 1'b0;
        end
        if (pipe_v[0]) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (!pipe_an[0][i]) d = i;
            v = -1;
            for (int i = 0; i < 16; i++) if (code_tab[i] == pipe_seg[0]) v = i;
            if (v >= 0) begin
                m_nib[d] = 4'(v); m_blank[d] = 1'b0; m_err[d] = 1'b0;
            end else if (pipe_seg[0] == 7'h7F) begin
                m_nib[d] = 4'h0; m_blank[d] = 1'b1; m_err[d] = 1'b0;
            end else begin
                m_nib[d] = 4'h0; m_blank[d] = 1'b0; m_err[d] = 1'b1;
            end
            m_seen[d] = 1'b1;
            if (m_seen == 4'hF) begin
                m_pub  = 1'b1;
                m_seen = 4'h0;
            end
        end
        pipe_v[0] = pipe_v[1]; pipe_seg[0] = pipe_seg[1]; pipe_an[0] = pipe_an[1];
        if (seg_in == m_last_seg && an_in == m_last_an) m_run++;
        else m_run = 1;
        m_last_seg = seg_in;
        m_last_an  = an_in;
        pipe_v[1]   = (m_run == SC) && (count_low(an_in) == 1);
        pipe_seg[1] = seg_in;
        pipe_an[1]  = an_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("valid",     32'(valid),     32'(exp_valid));
        check("hex_out",   32'(hex_out),   32'(exp_hex));
        check("blank_out", 32'(blank_out), 32'(exp_blank));
        check("err_out",   32'(err_out),   32'(exp_err));
        if (valid === 1'b1) vcount++;
    endtask

    task automatic dwell(input int digit, input logic [6:0] seg, input int n);
        an_in  = ~(4'b0001 << digit);
        seg_in = seg;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        an_in  = 4'hF;
        seg_in = 7'h7F;
        repeat (n) tick();
    endtask

    initial begin
        int v0;
        int k;
        int lat_edge;
        rst_n  = 1'b0;
        seg_in = 7'h7F;
        an_in  = 4'hF;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_hex",   32'(hex_out),   32'h0);
        check("rst_blank", 32'(blank_out), 32'h0);
        check("rst_err",   32'(err_out),   32'h0);
        check("rst_valid", 32'(valid),     32'h0);
        #1 rst_n = 1'b1;
        idle(3);

        // full frame 6, A, 1, D
        v0 = vcount;
        dwell(0, 7'b0000010, 10);
        dwell(1, 7'b0001000, 10);
        dwell(2, 7'b1111001, 10);
        dwell(3, 7'b0100001, 10);
        idle(4);
        check("t1_nvalid", 32'(vcount - v0), 32'd1);
        check("t1_hex",    32'(hex_out),     32'h0000D1A6);
        check("t1_blank",  32'(blank_out),   32'h0);
        check("t1_err",    32'(err_out),     32'h0);

        // all 16 codes on digit 0, eights elsewhere
        v0 = vcount;
        for (int v = 0; v < 16; v++) begin
            dwell(0, code_tab[v], 8);
            dwell(1, 7'b0000000, 8);
            dwell(2, 7'b0000000, 8);
            dwell(3, 7'b0000000, 8);
            check("t2_hex", 32'(hex_out), 32'({12'h888, 4'(v)}));
        end
        check("t2_nvalid", 32'(vcount - v0), 32'd16);

        // blank and error
        dwell(0, 7'b1000000, 8);
        dwell(1, 7'b0101010, 8);
        dwell(2, 7'b1111111, 8);
        dwell(3, 7'b1000000, 8);
        check("t3_hex",   32'(hex_out),   32'h0);
        check("t3_blank", 32'(blank_out), 32'b0100);
        check("t3_err",   32'(err_out),   32'b0010);

        // glitch on digit 0, illegal select, then digits 1..3 only
        v0 = vcount;
        dwell(0, 7'b1111001, 3);
        an_in  = 4'b1100;
        seg_in = 7'b1111001;
        repeat (6) tick();
        dwell(1, code_tab[3], 8);
        dwell(2, code_tab[4], 8);
        dwell(3, code_tab[5], 8);
        check("t4_nvalid", 32'(vcount - v0), 32'd0);

        // latency: digit 0 completes the frame; pair held from edge k
        an_in    = 4'b1110;
        seg_in   = code_tab[9];
        k        = edge_cnt + 1;
        lat_edge = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid === 1'b1 && lat_edge < 0) lat_edge = edge_cnt;
        end
        check("t5_latency", 32'(lat_edge), 32'(k + 6));
        check("t5_hex",     32'(hex_out),  32'h00005439);

        // reset mid-frame
        dwell(0, code_tab[1], 8);
        dwell(1, code_tab[2], 8);
        dwell(2, code_tab[3], 8);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_hex",   32'(hex_out), 32'h0);
        check("t6_rst_valid", 32'(valid),   32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        v0 = vcount;
        dwell(3, code_tab[7], 8);
        check("t6_partial", 32'(vcount - v0), 32'd0);
        dwell(0, code_tab[4], 8);
        dwell(1, code_tab[5], 8);
        dwell(2, code_tab[6], 8);
        check("t6_nvalid", 32'(vcount - v0), 32'd1);
        check("t6_hex",    32'(hex_out),     32'h00007654);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
